sindoku_board_ctrl: RTL and testbench
=====================================

Name: sindoku_board_ctrl

Overview:
- Parametrised Sudoku board controller, successor to the fixed 9x9 game FSM.
- Holds a SIDE x SIDE board, where SIDE = BOX*BOX, plus its solution. Board and solution are loaded at run time through a raster load port instead of being hard-coded.
- Provides cursor navigation and user digit entry, with clue cells write-protected.
- Runs a multi-cycle check pass that reports the error count and the location of the first error. Sits between the debounced button/switch front end and the display driver.

Parameters:
- BOX, 3: box side; board side SIDE = BOX*BOX, cell count NC = SIDE*SIDE.
- DW, 4: digit width; must satisfy 2**DW > SIDE.
- Derived (localparam, not overridable): RW = $clog2(SIDE); CW = $clog2(NC+1).

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high
- Ld_valid  in  1  load strobe, one cell per asserted cycle
- Ld_given  in  1  cell is a clue (write-protected)
- Ld_digit  in  DW  initial cell value (0 = empty)
- Ld_sol  in  DW  solution value for the cell
- R, L, U, D  in  1  single-cycle cursor move pulses
- C  in  1  single-cycle commit pulse; writes User_in to the cursor cell
- User_in  in  DW  digit to write (0 = clear)
- Check_solu  in  1  request check
- Ack  in  1  acknowledge result
- Cur_row, Cur_col  out  RW  cursor position
- Cell_val  out  DW  board value at cursor (combinational read)
- Cell_given  out  1  cursor cell is a clue
- Err_count  out  CW  mismatches found by the last check
- Err_row, Err_col  out  RW  first mismatch in raster order
- q_Load, q_Solve, q_Check, q_Correct, q_Incorrect  out  1  one-hot state

Behaviour:
- Reset:
  - state = LOAD; load pointer, cursor, Err_* and check indices = 0.
  - All board cells, given bits and solution cells = 0.
- LOAD:
  - On each Ld_valid, write the cell at the load pointer (raster order: row-major, col 0 first), then increment the pointer.
  - The cycle that writes cell NC-1 moves to SOLVE next; pointer returns to 0, cursor set to (0,0).
- Ld_valid is ignored in every state except LOAD.
- SOLVE, per cycle:
  - Check_solu has priority: go to CHECK; all moves and commits in that cycle are ignored; Err_count and scan indices are cleared.
  - Column: R alone = +1, L alone = -1, R and L together = no change. Rows behave the same way with D (+1) and U (-1).
  - Edges saturate: no move below 0 or above SIDE-1 (see optional feature).
  - C writes to the cell at the pre-move cursor position, even if a move occurs in the same cycle.
  - C is ignored if the cell is a clue or if User_in > SIDE.
- CHECK:
  - Compares one cell per cycle in raster order, starting at (0,0).
  - A mismatch is board != solution; empty cells count as mismatches.
  - On the first mismatch, latch Err_row/Err_col. Err_count increments on every mismatch.
  - After cell NC-1 is compared, go to CORRECT if the total count is 0, else INCORRECT. The final count includes cell NC-1.
  - Total of NC cycles in CHECK. Inputs other than Reset are ignored.
- CORRECT: on Ack, go to LOAD and clear board, given bits and solution (new puzzle expected). Err_* hold until the next check.
- INCORRECT: on Ack, return to SOLVE with the board and cursor preserved (retry).
- Illegal state encoding: recover to LOAD with the board cleared.
- Reset mid-check or mid-load: immediate return to the reset condition.

Optional Feature:
- Macro: SINDOKU_CURSOR_WRAP_EN.
- Defined: the cursor wraps at the edges (col SIDE-1 with R -> 0; col 0 with L -> SIDE-1; rows likewise). The row does not change on a column wrap.
- Undefined: edges saturate, as above.

Test Plan:
- BOX=3: load 81 cells (cell 0: given=0, digit=0, sol=2; cell 1: given=1, digit=5, sol=5) -> q_Solve asserted the cycle after the 81st Ld_valid; Cur=(0,0); Cell_val=0.
- At (0,1): C with User_in=7 -> Cell_val stays 5. Move L, then C with User_in=2 -> Cell_val=2. C with User_in=10 -> no change.
- Cursor at (0,0), pulse L and U -> stays (0,0) with the macro undefined; becomes (8,8) with it defined. R and L together -> column unchanged.
- Board correct except (4,6)=0 and (7,2)=9 (sol 8): Check_solu -> exactly 81 cycles in q_Check, then q_Incorrect, Err_count=2, Err=(4,6). Ack -> q_Solve with the board intact.
- Fix both cells and check again -> q_Correct, Err_count=0. Ack -> q_Load and Cell_val=0 everywhere.
- BOX=2 (SIDE=4, NC=16): Reset asserted midway through the 16-cell load -> q_Load, pointer 0. Reload 16 cells -> Solve, then a check runs in 16 cycles.

Source files
------------

// File: rtl/sindoku_board_ctrl.sv
// Parametrised Sudoku board controller: raster load, cursor/commit editing, multi-cycle check pass.
// Optional macro SINDOKU_CURSOR_WRAP_EN makes the cursor wrap at the board edges instead of saturating.
module sindoku_board_ctrl #(
  parameter  int BOX  = 3,
  parameter  int DW   = 4,
  localparam int SIDE = BOX * BOX,
  localparam int NC   = SIDE * SIDE,
  localparam int RW   = $clog2(SIDE),
  localparam int CW   = $clog2(NC + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Ld_valid,
  input  logic          Ld_given,
  input  logic [DW-1:0] Ld_digit,
  input  logic [DW-1:0] Ld_sol,
  input  logic          R,
  input  logic          L,
  input  logic          U,
  input  logic          D,
  input  logic          C,
  input  logic [DW-1:0] User_in,
  input  logic          Check_solu,
  input  logic          Ack,
  output logic [RW-1:0] Cur_row,
  output logic [RW-1:0] Cur_col,
  output logic [DW-1:0] Cell_val,
  output logic          Cell_given,
  output logic [CW-1:0] Err_count,
  output logic [RW-1:0] Err_row,
  output logic [RW-1:0] Err_col,
  output logic          q_Load,
  output logic          q_Solve,
  output logic          q_Check,
  output logic          q_Correct,
  output logic          q_Incorrect
);

  localparam int PW = $clog2(NC);
`ifdef SINDOKU_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [4:0] {
    S_LOAD      = 5'b00001,
    S_SOLVE     = 5'b00010,
    S_CHECK     = 5'b00100,
    S_CORRECT   = 5'b01000,
    S_INCORRECT = 5'b10000
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] board_q [NC];
  logic [DW-1:0] sol_q   [NC];
  logic [NC-1:0] given_q;

  logic [PW-1:0] ld_ptr_q;
  logic [RW-1:0] cur_row_q, cur_col_q;
  logic [RW-1:0] chk_row_q, chk_col_q;
  logic [RW-1:0] err_row_q, err_col_q;
  logic [CW-1:0] err_count_q;

  logic ld_we, solve_en, chk_start, chk_en, clear_board;

  function automatic logic [PW-1:0] cell_idx(input logic [RW-1:0] row, input logic [RW-1:0] col);
    return PW'(row) * PW'(SIDE) + PW'(col);
  endfunction

  // One axis of cursor motion: opposing pulses cancel, edges saturate or wrap.
  function automatic logic [RW-1:0] step_pos(input logic [RW-1:0] pos, input logic inc, input logic dec);
    logic [RW-1:0] nxt;
    nxt = pos;
    if (inc && !dec) begin
      if (pos == RW'(SIDE - 1)) nxt = WRAP ? '0 : pos;
      else                      nxt = pos + 1'b1;
    end else if (dec && !inc) begin
      if (pos == '0) nxt = WRAP ? RW'(SIDE - 1) : pos;
      else           nxt = pos - 1'b1;
    end
    return nxt;
  endfunction

  logic [PW-1:0] cur_idx, chk_idx;
  logic          chk_mismatch, chk_last, ld_last, commit_ok;

  assign cur_idx      = cell_idx(cur_row_q, cur_col_q);
  assign chk_idx      = cell_idx(chk_row_q, chk_col_q);
  assign chk_mismatch = (board_q[chk_idx] != sol_q[chk_idx]);
  assign chk_last     = (chk_row_q == RW'(SIDE - 1)) && (chk_col_q == RW'(SIDE - 1));
  assign ld_last      = (ld_ptr_q == PW'(NC - 1));
  assign commit_ok    = C && !given_q[cur_idx] && (User_in <= DW'(SIDE));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:      if (Ld_valid && ld_last) state_d = S_SOLVE;
      S_SOLVE:     if (Check_solu) state_d = S_CHECK;
      S_CHECK:     if (chk_last)
                     state_d = (err_count_q == '0 && !chk_mismatch) ? S_CORRECT : S_INCORRECT;
      S_CORRECT:   if (Ack) state_d = S_LOAD;
      S_INCORRECT: if (Ack) state_d = S_SOLVE;
      default:     state_d = S_LOAD;
    endcase
  end

  always_comb begin
    q_Load      = 1'b0;
    q_Solve     = 1'b0;
    q_Check     = 1'b0;
    q_Correct   = 1'b0;
    q_Incorrect = 1'b0;
    ld_we       = 1'b0;
    solve_en    = 1'b0;
    chk_start   = 1'b0;
    chk_en      = 1'b0;
    clear_board = 1'b0;
    case (state_q)
      S_LOAD:      begin q_Load = 1'b1; ld_we = Ld_valid; end
      S_SOLVE:     begin q_Solve = 1'b1; chk_start = Check_solu; solve_en = !Check_solu; end
      S_CHECK:     begin q_Check = 1'b1; chk_en = 1'b1; end
      S_CORRECT:   begin q_Correct = 1'b1; clear_board = Ack; end
      S_INCORRECT: q_Incorrect = 1'b1;
      default:     clear_board = 1'b1;
    endcase
  end

  // NOTE: the board is architecturally cleared by reset, so these arrays are reset flops, not a RAM.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NC; i++) begin
        board_q[i] <= '0;
        sol_q[i]   <= '0;
      end
      given_q <= '0;
    end else if (clear_board) begin
      for (int i = 0; i < NC; i++) begin
        board_q[i] <= '0;
        sol_q[i]   <= '0;
      end
      given_q <= '0;
    end else if (ld_we) begin
      board_q[ld_ptr_q] <= Ld_digit;
      sol_q[ld_ptr_q]   <= Ld_sol;
      given_q[ld_ptr_q] <= Ld_given;
    end else if (solve_en && commit_ok) begin
      board_q[cur_idx] <= User_in;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ld_ptr_q    <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      chk_row_q   <= '0;
      chk_col_q   <= '0;
      err_row_q   <= '0;
      err_col_q   <= '0;
      err_count_q <= '0;
    end else begin
      if (clear_board) ld_ptr_q <= '0;
      if (ld_we) begin
        if (ld_last) begin
          ld_ptr_q  <= '0;
          cur_row_q <= '0;
          cur_col_q <= '0;
        end else begin
          ld_ptr_q <= ld_ptr_q + 1'b1;
        end
      end
      if (solve_en) begin
        cur_col_q <= step_pos(cur_col_q, R, L);
        cur_row_q <= step_pos(cur_row_q, D, U);
      end
      if (chk_start) begin
        err_count_q <= '0;
        chk_row_q   <= '0;
        chk_col_q   <= '0;
      end
      if (chk_en) begin
        if (chk_mismatch) begin
          err_count_q <= err_count_q + 1'b1;
          // A zero running count means this is the first mismatch of the pass.
          if (err_count_q == '0) begin
            err_row_q <= chk_row_q;
            err_col_q <= chk_col_q;
          end
        end
        if (chk_col_q == RW'(SIDE - 1)) begin
          chk_col_q <= '0;
          chk_row_q <= chk_last ? '0 : chk_row_q + 1'b1;
        end else begin
          chk_col_q <= chk_col_q + 1'b1;
        end
      end
    end
  end

  assign Cur_row    = cur_row_q;
  assign Cur_col    = cur_col_q;
  assign Cell_val   = board_q[cur_idx];
  assign Cell_given = given_q[cur_idx];
  assign Err_count  = err_count_q;
  assign Err_row    = err_row_q;
  assign Err_col    = err_col_q;

endmodule

// File: tb/tb_sindoku_board_ctrl.sv
// Randomised self-checking bench for sindoku_board_ctrl: a 9x9 instance against a board/cursor model,
// plus a 4x4 instance exercising reset during load and check.
module tb_sindoku_board_ctrl;

  localparam int S3 = 9, N3 = 81, S2 = 4, N2 = 16;
`ifdef SINDOKU_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset, Ld_valid, Ld_given, R, L, U, D, C, Check_solu, Ack;
  logic [3:0] Ld_digit, Ld_sol, User_in;
  logic [3:0] Cur_row, Cur_col, Cell_val, Err_row, Err_col;
  logic       Cell_given;
  logic [6:0] Err_count;
  logic       q_Load, q_Solve, q_Check, q_Correct, q_Incorrect;

  logic       b_reset, b_ld_valid, b_ld_given, b_check, b_ack;
  logic [3:0] b_ld_digit, b_ld_sol, b_cell_val;
  logic [1:0] b_cur_row, b_cur_col, b_err_row, b_err_col;
  logic       b_cell_given;
  logic [4:0] b_err_count;
  logic       b_q_load, b_q_solve, b_q_check, b_q_correct, b_q_incorrect;

  sindoku_board_ctrl #(.BOX(3), .DW(4)) dut3 (
    .Clk(clk), .Reset(Reset), .Ld_valid(Ld_valid), .Ld_given(Ld_given), .Ld_digit(Ld_digit),
    .Ld_sol(Ld_sol), .R(R), .L(L), .U(U), .D(D), .C(C), .User_in(User_in),
    .Check_solu(Check_solu), .Ack(Ack), .Cur_row(Cur_row), .Cur_col(Cur_col),
    .Cell_val(Cell_val), .Cell_given(Cell_given), .Err_count(Err_count),
    .Err_row(Err_row), .Err_col(Err_col), .q_Load(q_Load), .q_Solve(q_Solve),
    .q_Check(q_Check), .q_Correct(q_Correct), .q_Incorrect(q_Incorrect)
  );

  sindoku_board_ctrl #(.BOX(2), .DW(4)) dut2 (
    .Clk(clk), .Reset(b_reset), .Ld_valid(b_ld_valid), .Ld_given(b_ld_given), .Ld_digit(b_ld_digit),
    .Ld_sol(b_ld_sol), .R(1'b0), .L(1'b0), .U(1'b0), .D(1'b0), .C(1'b0), .User_in(4'd0),
    .Check_solu(b_check), .Ack(b_ack), .Cur_row(b_cur_row), .Cur_col(b_cur_col),
    .Cell_val(b_cell_val), .Cell_given(b_cell_given), .Err_count(b_err_count),
    .Err_row(b_err_row), .Err_col(b_err_col), .q_Load(b_q_load), .q_Solve(b_q_solve),
    .q_Check(b_q_check), .q_Correct(b_q_correct), .q_Incorrect(b_q_incorrect)
  );

  int m_board[N3], m_sol[N3];
  bit m_given[N3];
  int m_row, m_col;
  int b_dig[N2], b_sol[N2];
  bit b_giv[N2];

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mv(int p, bit inc, bit dec, int side);
    if (inc && !dec) return (p == side - 1) ? (WRAP ? 0 : p) : p + 1;
    if (dec && !inc) return (p == 0) ? (WRAP ? side - 1 : p) : p - 1;
    return p;
  endfunction

  task automatic expect_view(input string tag);
    check({tag, ".row"}, Cur_row, m_row);
    check({tag, ".col"}, Cur_col, m_col);
    check({tag, ".val"}, Cell_val, m_board[m_row * S3 + m_col]);
    check({tag, ".given"}, Cell_given, m_given[m_row * S3 + m_col]);
  endtask

  task automatic solve_cycle(input bit r, input bit l, input bit u, input bit d,
                             input bit c, input int uin);
    int idx;
    idx = m_row * S3 + m_col;
    if (c && !m_given[idx] && uin <= S3) m_board[idx] = uin;
    m_col = mv(m_col, r, l, S3);
    m_row = mv(m_row, d, u, S3);
    R = r; L = l; U = u; D = d; C = c; User_in = 4'(uin);
    tick();
    R = 0; L = 0; U = 0; D = 0; C = 0;
    check("solve.state", q_Solve, 1);
    expect_view("solve");
  endtask

  task automatic move_to(input int r, input int c);
    while (m_col < c) solve_cycle(1, 0, 0, 0, 0, 0);
    while (m_col > c) solve_cycle(0, 1, 0, 0, 0, 0);
    while (m_row < r) solve_cycle(0, 0, 0, 1, 0, 0);
    while (m_row > r) solve_cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic load3();
    for (int i = 0; i < N3; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      Ld_valid = 1; Ld_given = m_given[i]; Ld_digit = 4'(m_board[i]); Ld_sol = 4'(m_sol[i]);
      tick();
      Ld_valid = 0;
      if (i == N3 - 2) check("load.pending", q_Load, 1);
    end
    m_row = 0; m_col = 0;
    check("load.solve", q_Solve, 1);
    expect_view("load.done");
  endtask

  task automatic run_check3(input string tag);
    int cnt, first, n;
    cnt = 0; first = -1; n = 0;
    for (int i = 0; i < N3; i++)
      if (m_board[i] != m_sol[i]) begin
        if (first < 0) first = i;
        cnt++;
      end
    Check_solu = 1; R = 1; C = 1; User_in = 4'd1;
    tick();
    Check_solu = 0; R = 0; C = 0;
    while (q_Check && n < 200) begin
      n++;
      R = 1'($urandom); L = 1'($urandom); D = 1'($urandom); C = 1'($urandom);
      Ld_valid = 1'($urandom); Ack = 1'($urandom); Check_solu = 1'($urandom);
      User_in = 4'($urandom_range(0, 9));
      tick();
      R = 0; L = 0; D = 0; C = 0; Ld_valid = 0; Ack = 0; Check_solu = 0;
    end
    check({tag, ".cycles"}, n, N3);
    check({tag, ".correct"}, q_Correct, cnt == 0);
    check({tag, ".incorrect"}, q_Incorrect, cnt != 0);
    check({tag, ".count"}, Err_count, cnt);
    if (cnt != 0) begin
      check({tag, ".err_row"}, Err_row, first / S3);
      check({tag, ".err_col"}, Err_col, first % S3);
    end
    expect_view({tag, ".hold"});
  endtask

  task automatic load2(input int n);
    for (int i = 0; i < n; i++) begin
      b_ld_valid = 1; b_ld_given = b_giv[i]; b_ld_digit = 4'(b_dig[i]); b_ld_sol = 4'(b_sol[i]);
      tick();
      b_ld_valid = 0;
      if (i == n - 2) check("b.load.pending", b_q_load, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, n;
    Reset = 1; Ld_valid = 0; Ld_given = 0; Ld_digit = 0; Ld_sol = 0;
    R = 0; L = 0; U = 0; D = 0; C = 0; User_in = 0; Check_solu = 0; Ack = 0;
    b_reset = 1; b_ld_valid = 0; b_ld_given = 0; b_ld_digit = 0; b_ld_sol = 0; b_check = 0; b_ack = 0;
    repeat (2) tick();
    Reset = 0; b_reset = 0;
    tick();
    check("reset.load", q_Load, 1);
    check("reset.onehot", {q_Solve, q_Check, q_Correct, q_Incorrect}, 0);
    check("reset.cur", {Cur_row, Cur_col}, 0);
    check("reset.err", {Err_count, Err_row, Err_col}, 0);
    check("reset.cell", Cell_val, 0);

    for (int i = 0; i < N3; i++) begin
      m_sol[i]   = $urandom_range(1, 9);
      m_given[i] = ($urandom_range(0, 2) == 0);
      m_board[i] = m_given[i] ? m_sol[i] : $urandom_range(0, 9);
    end
    m_given[0] = 0; m_board[0] = 0; m_sol[0] = 2;
    m_given[1] = 1; m_board[1] = 5; m_sol[1] = 5;
    m_given[4 * S3 + 6] = 0;
    m_given[7 * S3 + 2] = 0; m_sol[7 * S3 + 2] = 8;
    load3();

    solve_cycle(1, 0, 0, 0, 0, 0);
    check("plan.clue_val", Cell_val, 5);
    solve_cycle(0, 0, 0, 0, 1, 7);
    solve_cycle(0, 1, 0, 0, 0, 0);
    solve_cycle(0, 0, 0, 0, 1, 2);
    check("plan.commit_val", Cell_val, 2);
    solve_cycle(0, 0, 0, 0, 1, 10);
    solve_cycle(0, 1, 1, 0, 0, 0);
    check("edge.row", Cur_row, WRAP ? 8 : 0);
    check("edge.col", Cur_col, WRAP ? 8 : 0);
    solve_cycle(1, 1, 0, 0, 0, 0);
    move_to(0, 0);
    solve_cycle(1, 0, 0, 0, 1, 3);
    solve_cycle(0, 1, 0, 0, 0, 0);

    repeat (300)
      solve_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15));

    for (int r = 0; r < S3; r++)
      for (int c = 0; c < S3; c++)
        if (!m_given[r * S3 + c]) begin
          move_to(r, c);
          solve_cycle(0, 0, 0, 0, 1, (r == 4 && c == 6) ? 0 :
                                     (r == 7 && c == 2) ? 9 : m_sol[r * S3 + c]);
        end
    move_to(2, 3);
    run_check3("chk1");
    check("plan.err_count", Err_count, 2);
    Ack = 1; tick(); Ack = 0;
    check("ack1.solve", q_Solve, 1);
    expect_view("ack1");

    move_to(4, 6);
    solve_cycle(0, 0, 0, 0, 1, m_sol[4 * S3 + 6]);
    move_to(7, 2);
    solve_cycle(0, 0, 0, 0, 1, 8);
    move_to(0, 1);
    run_check3("chk2");
    Ack = 1; tick(); Ack = 0;
    check("ack2.load", q_Load, 1);
    check("ack2.val", Cell_val, 0);
    check("ack2.given", Cell_given, 0);
    check("ack2.err_hold", Err_count, 0);

    for (int i = 0; i < N2; i++) begin
      b_sol[i] = $urandom_range(1, 4);
      b_giv[i] = ($urandom_range(0, 2) == 0);
      b_dig[i] = b_giv[i] ? b_sol[i] : $urandom_range(0, 4);
    end
    b_giv[0] = 1; b_dig[0] = b_sol[0];
    b_giv[5] = 0; b_dig[5] = 0;
    load2(8);
    check("b.mid.val", b_cell_val, b_dig[0]);
    #2 b_reset = 1;
    #1;
    check("b.rst_load.state", b_q_load, 1);
    check("b.rst_load.val", b_cell_val, 0);
    tick();
    b_reset = 0;
    load2(N2);
    check("b.load.solve", b_q_solve, 1);
    check("b.load.cur", {b_cur_row, b_cur_col}, 0);
    b_check = 1; tick(); b_check = 0;
    repeat (5) tick();
    check("b.midchk.state", b_q_check, 1);
    #2 b_reset = 1;
    #1;
    check("b.rst_chk.load", b_q_load, 1);
    check("b.rst_chk.check", b_q_check, 0);
    check("b.rst_chk.count", b_err_count, 0);
    tick();
    b_reset = 0;
    load2(N2);
    cnt = 0; first = -1; n = 0;
    for (int i = 0; i < N2; i++)
      if (b_dig[i] != b_sol[i]) begin
        if (first < 0) first = i;
        cnt++;
      end
    b_check = 1; tick(); b_check = 0;
    while (b_q_check && n < 100) begin
      n++;
      tick();
    end
    check("b.chk.cycles", n, N2);
    check("b.chk.incorrect", b_q_incorrect, cnt != 0);
    check("b.chk.count", b_err_count, cnt);
    if (cnt != 0) begin
      check("b.chk.err_row", b_err_row, first / S2);
      check("b.chk.err_col", b_err_col, first % S2);
    end
    b_ack = 1; tick(); b_ack = 0;
    check("b.ack.solve", b_q_solve, cnt != 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
